// File: rtl/line_draw_ctrl_pkg.sv
// Shared types and constants for the Bresenham line sequencer.
package line_pkg;

    localparam int COORD_W = 9;
    localparam int ERR_W   = COORD_W + 2;
    localparam int E2_W    = COORD_W + 3;

    typedef logic [COORD_W-1:0]      coord_t;
    typedef logic signed [ERR_W-1:0] err_t;
    typedef logic signed [E2_W-1:0]  e2_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Unsigned distance between two coordinates.
    function automatic coord_t abs_diff(input coord_t a, input coord_t b);
        return (a >= b) ? coord_t'(a - b) : coord_t'(b - a);
    endfunction

endpackage

// File: rtl/line_draw_ctrl_if.sv
// Control, endpoint and pixel-stream bundle of the line sequencer.
// Optional macro LINE_DRAW_ABORT_EN adds the abort request.
interface line_draw_ctrl_if;
    import line_pkg::*;

    logic   start;
    coord_t x1;
    coord_t y1;
    coord_t x2;
    coord_t y2;
    logic   busy;
    logic   done;
    coord_t pix_x;
    coord_t pix_y;
    logic   pix_valid;
    logic   pix_ready;

`ifdef LINE_DRAW_ABORT_EN
    logic   abort;

    modport master (
        output start, x1, y1, x2, y2, pix_ready, abort,
        input  busy, done, pix_x, pix_y, pix_valid
    );

    modport slave (
        input  start, x1, y1, x2, y2, pix_ready, abort,
        output busy, done, pix_x, pix_y, pix_valid
    );
`else
    modport master (
        output start, x1, y1, x2, y2, pix_ready,
        input  busy, done, pix_x, pix_y, pix_valid
    );

    modport slave (
        input  start, x1, y1, x2, y2, pix_ready,
        output busy, done, pix_x, pix_y, pix_valid
    );
`endif

endinterface

// File: rtl/line_draw_ctrl_step.sv
// One Bresenham step: next pixel and error term from the current one.
// Both axis rules are evaluated on the same doubled error, and the error
// update is the sum of whichever rules fire.
module bresenham_step
    import line_pkg::*;
(
    input  coord_t i_cur_x,
    input  coord_t i_cur_y,
    input  coord_t i_end_x,
    input  coord_t i_end_y,
    input  err_t   i_err,
    input  err_t   i_dx,
    input  err_t   i_dy,
    input  logic   i_sx_neg,
    input  logic   i_sy_neg,
    output coord_t o_nxt_x,
    output coord_t o_nxt_y,
    output err_t   o_nxt_err,
    output logic   o_last
);

    e2_t  w_e2;
    e2_t  w_dx_ext;
    e2_t  w_dy_ext;
    logic w_step_x;
    logic w_step_y;

    assign w_e2     = $signed({i_err, 1'b0});
    assign w_dx_ext = $signed({i_dx[ERR_W-1], i_dx});
    assign w_dy_ext = $signed({i_dy[ERR_W-1], i_dy});
    assign w_step_x = (w_e2 >= w_dy_ext);
    assign w_step_y = (w_e2 <= w_dx_ext);

    // Apply the x and y rules together; cur never leaves the bounding box.
    always_comb begin
        o_nxt_x   = i_cur_x;
        o_nxt_y   = i_cur_y;
        o_nxt_err = i_err;
        if (w_step_x) begin
            o_nxt_x   = i_sx_neg ? coord_t'(i_cur_x - coord_t'(1)) : coord_t'(i_cur_x + coord_t'(1));
            o_nxt_err = o_nxt_err + i_dy;
        end
        if (w_step_y) begin
            o_nxt_y   = i_sy_neg ? coord_t'(i_cur_y - coord_t'(1)) : coord_t'(i_cur_y + coord_t'(1));
            o_nxt_err = o_nxt_err + i_dx;
        end
    end

    assign o_last = (i_cur_x == i_end_x) && (i_cur_y == i_end_y);

endmodule

// File: rtl/line_draw_ctrl.sv
// Bresenham line sequencer: latches endpoints on start and streams every
// pixel from (x1,y1) to (x2,y2) over a valid/ready handshake.
// Optional macro LINE_DRAW_ABORT_EN adds an abort input on the bus.
//
// state | meaning
// IDLE  | waiting for start; endpoints latched on start
// SETUP | one cycle computing deltas, steps and initial error
// DRAW  | presenting cur on the pixel stream, stepping on acceptance
// DONE  | one-cycle done pulse, then back to IDLE
module line_draw_ctrl
    import line_pkg::*;
(
    input  logic             HCLK,
    input  logic             HRESETn,
    line_draw_ctrl_if.slave  bus
);

    state_t r_state;
    state_t w_next;

    coord_t r_x1, r_y1, r_x2, r_y2;
    coord_t r_cur_x, r_cur_y;
    err_t   r_dx, r_dy, r_err;
    logic   r_sx_neg, r_sy_neg;

    coord_t w_nxt_x, w_nxt_y;
    err_t   w_nxt_err;
    logic   w_last;
    logic   w_accept;
    logic   w_abort;
    err_t   w_dx_setup;
    err_t   w_dy_setup;

`ifdef LINE_DRAW_ABORT_EN
    assign w_abort = bus.abort && ((r_state == SETUP) || (r_state == DRAW));
`else
    assign w_abort = 1'b0;
`endif

    assign w_accept   = (r_state == DRAW) && bus.pix_ready;
    assign w_dx_setup = err_t'({2'b00, abs_diff(r_x2, r_x1)});
    assign w_dy_setup = err_t'(0) - err_t'({2'b00, abs_diff(r_y2, r_y1)});

    bresenham_step u_step (
        .i_cur_x   (r_cur_x),
        .i_cur_y   (r_cur_y),
        .i_end_x   (r_x2),
        .i_end_y   (r_y2),
        .i_err     (r_err),
        .i_dx      (r_dx),
        .i_dy      (r_dy),
        .i_sx_neg  (r_sx_neg),
        .i_sy_neg  (r_sy_neg),
        .o_nxt_x   (w_nxt_x),
        .o_nxt_y   (w_nxt_y),
        .o_nxt_err (w_nxt_err),
        .o_last    (w_last)
    );

    // State register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs; abort overrides acceptance.
    always_comb begin
        w_next        = r_state;
        bus.busy      = (r_state != IDLE);
        bus.done      = (r_state == DONE);
        bus.pix_valid = (r_state == DRAW);
        bus.pix_x     = r_cur_x;
        bus.pix_y     = r_cur_y;
        case (r_state)
            IDLE:    if (bus.start) w_next = SETUP;
            SETUP:   w_next = DRAW;
            DRAW:    if (w_accept && w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (w_abort) begin
            w_next = IDLE;
        end
    end

    // Endpoint latch, setup arithmetic and per-pixel stepping.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_x1     <= '0;
            r_y1     <= '0;
            r_x2     <= '0;
            r_y2     <= '0;
            r_cur_x  <= '0;
            r_cur_y  <= '0;
            r_dx     <= '0;
            r_dy     <= '0;
            r_err    <= '0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
        end else if (!w_abort) begin
            if ((r_state == IDLE) && bus.start) begin
                r_x1 <= bus.x1;
                r_y1 <= bus.y1;
                r_x2 <= bus.x2;
                r_y2 <= bus.y2;
            end
            if (r_state == SETUP) begin
                r_dx     <= w_dx_setup;
                r_dy     <= w_dy_setup;
                r_err    <= w_dx_setup + w_dy_setup;
                r_sx_neg <= (r_x2 < r_x1);
                r_sy_neg <= (r_y2 < r_y1);
                r_cur_x  <= r_x1;
                r_cur_y  <= r_y1;
            end
            if (w_accept && !w_last) begin
                r_cur_x <= w_nxt_x;
                r_cur_y <= w_nxt_y;
                r_err   <= w_nxt_err;
            end
        end
    end

endmodule
